// File: rtl/frame_cfg_pkg.sv
// Shared types and helpers for the column configuration frame sequencer.
package frame_cfg_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, STROBE} state_t;

  localparam int unsigned HDR_IDX_W = 8;
  localparam int unsigned HDR_CNT_W = 8;
  localparam int unsigned ONEHOT_W  = 64;

  // One-hot decode; callers truncate to their bus width (row/frame counts must stay <= 64).
  function automatic logic [ONEHOT_W-1:0] onehot(input logic [HDR_CNT_W-1:0] pos);
    return ONEHOT_W'(1) << pos;
  endfunction

endpackage

// File: rtl/frame_config_ctrl.sv
// Configuration frame sequencer: header + N row words -> one-hot RowSelect pulses, then FrameStrobe.
// Optional feature: define FRAME_CTRL_DONE_COUNT_EN to add the 16-bit frames_done counter.
module frame_config_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumberOfRows    = 16
) (
  input  logic                       CLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [NumberOfRows-1:0]    RowSelect,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clr
`ifdef FRAME_CTRL_DONE_COUNT_EN
  ,
  output logic [15:0]                frames_done
`endif
);

  state_t                       state, next_state;
  logic [HDR_IDX_W-1:0]         idx_q, idx_d;
  logic [HDR_CNT_W-1:0]         cnt_q, cnt_d;
  logic [HDR_CNT_W-1:0]         row_q, row_d;
  logic [FrameBitsPerRow-1:0]   data_d;
  logic [NumberOfRows-1:0]      rowsel_d;
  logic [MaxFramesPerCol-1:0]   strobe_d;
  logic                         err_d, ready_d, busy_d;
  logic                         xfer;
  logic [HDR_IDX_W-1:0]         hdr_idx;
  logic [HDR_CNT_W-1:0]         hdr_cnt;
  logic                         hdr_bad;

  assign xfer    = s_valid && s_ready;
  assign hdr_idx = s_data[FrameBitsPerRow-1 -: HDR_IDX_W];
  assign hdr_cnt = s_data[HDR_CNT_W-1:0];
  assign hdr_bad = (32'(hdr_idx) >= MaxFramesPerCol) || (hdr_cnt == '0) ||
                   (32'(hdr_cnt) > NumberOfRows);

  // State register
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next state and next values of every registered output
  always_comb begin
    next_state = state;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    data_d     = FrameData;
    rowsel_d   = '0;
    strobe_d   = '0;
    err_d      = err;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (hdr_bad) begin
            err_d = 1'b1;
          end else begin
            idx_d      = hdr_idx;
            cnt_d      = hdr_cnt;
            row_d      = '0;
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          data_d   = s_data;
          rowsel_d = NumberOfRows'(onehot(row_q));
          row_d    = row_q + HDR_CNT_W'(1);
          if (row_q == cnt_q - HDR_CNT_W'(1)) next_state = STROBE;
        end
      end
      STROBE: begin
        strobe_d   = MaxFramesPerCol'(onehot(HDR_CNT_W'(idx_q)));
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (err_clr) err_d = 1'b0;
    ready_d = (next_state != STROBE);
    busy_d  = (next_state != IDLE) || (strobe_d != '0);
  end

  // Output and datapath registers
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      idx_q       <= '0;
      cnt_q       <= '0;
      row_q       <= '0;
      FrameData   <= '0;
      RowSelect   <= '0;
      FrameStrobe <= '0;
      err         <= 1'b0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      FrameData   <= data_d;
      RowSelect   <= rowsel_d;
      FrameStrobe <= strobe_d;
      err         <= err_d;
      s_ready     <= ready_d;
      busy        <= busy_d;
    end
  end

`ifdef FRAME_CTRL_DONE_COUNT_EN
  // Committed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn)                 frames_done <= '0;
    else if (FrameStrobe != '0)  frames_done <= frames_done + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_config_ctrl.sv
// Directed, table-driven bench for frame_config_ctrl (default parameters).
module tb_frame_config_ctrl;

  logic        CLK;
  logic        resetn;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] FrameData;
  logic [15:0] RowSelect;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        err;
  logic        err_clr;
`ifdef FRAME_CTRL_DONE_COUNT_EN
  logic [15:0] frames_done;
`endif

  int checks = 0;
  int errors = 0;

  frame_config_ctrl dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .RowSelect(RowSelect), .FrameStrobe(FrameStrobe),
    .busy(busy), .err(err), .err_clr(err_clr)
`ifdef FRAME_CTRL_DONE_COUNT_EN
    , .frames_done(frames_done)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        clr;
    logic        rdy;
    logic [15:0] rs;
    logic [31:0] fd;
    logic [19:0] fs;
    logic        e;
    logic        b;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic clr,
                              input logic rdy, input logic [15:0] rs, input logic [31:0] fd,
                              input logic [19:0] fs, input logic e, input logic b);
    vec_t t;
    t.v = v; t.d = d; t.clr = clr; t.rdy = rdy; t.rs = rs; t.fd = fd; t.fs = fs; t.e = e; t.b = b;
    return t;
  endfunction

  task automatic compare(input string nm, input vec_t t);
    logic [70:0] act, exp;
    act = {s_ready, RowSelect, FrameData, FrameStrobe, err, busy};
    exp = {t.rdy, t.rs, t.fd, t.fs, t.e, t.b};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b rs=%h fd=%h fs=%h err=%b busy=%b, expected rdy=%b rs=%h fd=%h fs=%h err=%b busy=%b",
               nm, s_ready, RowSelect, FrameData, FrameStrobe, err, busy,
               t.rdy, t.rs, t.fd, t.fs, t.e, t.b);
    end
  endtask

  // Drive inputs mid-cycle, sample the outputs just after the following rising edge
  task automatic run(input string nm, input vec_t t);
    @(negedge CLK);
    s_valid = t.v; s_data = t.d; err_clr = t.clr;
    @(posedge CLK);
    #1;
    compare(nm, t);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = mk(1, 32'h03000002, 0, 1, 16'h0000, 32'h00000000, 20'h00000, 0, 1);
    tbl[1]  = mk(1, 32'hDEADBEEF, 0, 1, 16'h0001, 32'hDEADBEEF, 20'h00000, 0, 1);
    tbl[2]  = mk(1, 32'h12345678, 0, 0, 16'h0002, 32'h12345678, 20'h00000, 0, 1);
    tbl[3]  = mk(0, 32'h0,        0, 1, 16'h0000, 32'h12345678, 20'h00008, 0, 1);
    tbl[4]  = mk(0, 32'h0,        0, 1, 16'h0000, 32'h12345678, 20'h00000, 0, 0);
    tbl[5]  = mk(1, 32'h14000001, 0, 1, 16'h0000, 32'h12345678, 20'h00000, 1, 0);
    tbl[6]  = mk(1, 32'h00000000, 0, 1, 16'h0000, 32'h12345678, 20'h00000, 1, 0);
    tbl[7]  = mk(1, 32'h00000011, 0, 1, 16'h0000, 32'h12345678, 20'h00000, 1, 0);
    tbl[8]  = mk(0, 32'h0,        1, 1, 16'h0000, 32'h12345678, 20'h00000, 0, 0);
    tbl[9]  = mk(1, 32'h14000001, 1, 1, 16'h0000, 32'h12345678, 20'h00000, 0, 0);
    tbl[10] = mk(1, 32'h13000001, 0, 1, 16'h0000, 32'h12345678, 20'h00000, 0, 1);
    tbl[11] = mk(1, 32'hA5A5A5A5, 0, 0, 16'h0001, 32'hA5A5A5A5, 20'h00000, 0, 1);
    tbl[12] = mk(0, 32'h0,        0, 1, 16'h0000, 32'hA5A5A5A5, 20'h80000, 0, 1);
    tbl[13] = mk(0, 32'h0,        0, 1, 16'h0000, 32'hA5A5A5A5, 20'h00000, 0, 0);

    // Reset: outputs all zero while held, ready after release
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    compare("reset_hold", mk(0, 0, 0, 0, 16'h0, 32'h0, 20'h0, 0, 0));
    @(negedge CLK);
    resetn = 1'b1;
    run("reset_release", mk(0, 0, 0, 1, 16'h0, 32'h0, 20'h0, 0, 0));

    // Nominal frame, bad headers, err_clr priority, max-index frame
    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);

    // Stall: N=3, five idle cycles between rows
    run("stall_hdr", mk(1, 32'h05000003, 0, 1, 16'h0, 32'hA5A5A5A5, 20'h0, 0, 1));
    for (int r = 0; r < 3; r++) begin
      run($sformatf("stall_row%0d", r),
          mk(1, 32'(r + 1), 0, (r != 2), 16'(1 << r), 32'(r + 1), 20'h0, 0, 1));
      if (r != 2)
        for (int k = 0; k < 5; k++)
          run($sformatf("stall_gap%0d_%0d", r, k), mk(0, 0, 0, 1, 16'h0, 32'(r + 1), 20'h0, 0, 1));
    end
    run("stall_strobe", mk(0, 0, 0, 1, 16'h0, 32'h3, 20'h00020, 0, 1));
    run("stall_idle",   mk(0, 0, 0, 1, 16'h0, 32'h3, 20'h00000, 0, 0));

    // Back-to-back: second header accepted in the strobe cycle
    run("b2b_hdr1",   mk(1, 32'h01000001, 0, 1, 16'h0, 32'h3,        20'h0, 0, 1));
    run("b2b_row1",   mk(1, 32'h11111111, 0, 0, 16'h1, 32'h11111111, 20'h0, 0, 1));
    run("b2b_strobe1",mk(0, 0,            0, 1, 16'h0, 32'h11111111, 20'h2, 0, 1));
    run("b2b_hdr2",   mk(1, 32'h02000001, 0, 1, 16'h0, 32'h11111111, 20'h0, 0, 1));
    run("b2b_row2",   mk(1, 32'h22222222, 0, 0, 16'h1, 32'h22222222, 20'h0, 0, 1));
    run("b2b_strobe2",mk(0, 0,            0, 1, 16'h0, 32'h22222222, 20'h4, 0, 1));
    run("b2b_idle",   mk(0, 0,            0, 1, 16'h0, 32'h22222222, 20'h0, 0, 0));

    // Full column: N = NumberOfRows, frame 0
    run("full_hdr", mk(1, 32'h00000010, 0, 1, 16'h0, 32'h22222222, 20'h0, 0, 1));
    for (int i = 0; i < 16; i++)
      run($sformatf("full_row%0d", i),
          mk(1, 32'hC0DE0000 + 32'(i), 0, (i != 15), 16'(1 << i), 32'hC0DE0000 + 32'(i), 20'h0, 0, 1));
    run("full_strobe", mk(0, 0, 0, 1, 16'h0, 32'hC0DE000F, 20'h1, 0, 1));
    run("full_idle",   mk(0, 0, 0, 1, 16'h0, 32'hC0DE000F, 20'h0, 0, 0));

    // Reset mid-frame after row 1 of N=4
    run("mid_hdr",  mk(1, 32'h07000004, 0, 1, 16'h0, 32'hC0DE000F, 20'h0, 0, 1));
    run("mid_row1", mk(1, 32'hAAAA0001, 0, 1, 16'h1, 32'hAAAA0001, 20'h0, 0, 1));
`ifdef FRAME_CTRL_DONE_COUNT_EN
    chk16("frames_done_before_reset", frames_done, 16'd6);
`endif
    @(negedge CLK);
    resetn = 1'b0; s_valid = 1'b0;
    #1;
    compare("mid_reset_async", mk(0, 0, 0, 0, 16'h0, 32'h0, 20'h0, 0, 0));
    repeat (3) @(posedge CLK);
    #1;
    compare("mid_reset_hold", mk(0, 0, 0, 0, 16'h0, 32'h0, 20'h0, 0, 0));
    @(negedge CLK);
    resetn = 1'b1;
    run("mid_release", mk(0, 0, 0, 1, 16'h0, 32'h0, 20'h0, 0, 0));
    run("post_hdr",    mk(1, 32'h07000001, 0, 1, 16'h0, 32'h0,        20'h0,  0, 1));
    run("post_row",    mk(1, 32'hBBBB0001, 0, 0, 16'h1, 32'hBBBB0001, 20'h0,  0, 1));
    run("post_strobe", mk(0, 0,            0, 1, 16'h0, 32'hBBBB0001, 20'h80, 0, 1));
    run("post_idle",   mk(0, 0,            0, 1, 16'h0, 32'hBBBB0001, 20'h0,  0, 0));
`ifdef FRAME_CTRL_DONE_COUNT_EN
    chk16("frames_done_after_reset", frames_done, 16'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_config_ctrl.md
# frame_config_ctrl

Configuration frame sequencer for one fabric column. It accepts a word stream of frame headers and row data over a valid/ready handshake. It drives the column's FrameData bus with a one-hot row write-enable, then issues a single-cycle FrameStrobe pulse that commits the assembled frame into the tiles' configuration latches. It sits between the bitstream source (UART/SPI config port) and the column's FrameData/FrameStrobe daisy chain.

## Interface
- MaxFramesPerCol, 20, number of frames per column; width of FrameStrobe
- FrameBitsPerRow, 32, FrameData width and stream word width; minimum 16
- NumberOfRows, 16, tile rows in the column; width of RowSelect

- CLK  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- s_data  in  FrameBitsPerRow  stream word (header or row data)
- s_valid  in  1  s_data valid
- s_ready  out  1  controller accepts s_data this cycle
- FrameData  out  FrameBitsPerRow  row data, registered
- RowSelect  out  NumberOfRows  one-hot row write-enable, one-cycle pulse
- FrameStrobe  out  MaxFramesPerCol  one-hot frame commit, one-cycle pulse
- busy  out  1  high when state != IDLE or FrameStrobe != 0
- err  out  1  sticky header error
- err_clr  in  1  synchronous clear of err
- frames_done  out  16  committed-frame count (only with FRAME_CTRL_DONE_COUNT_EN)

Clock and reset are decided: one clock CLK; reset resetn is asynchronous and active-low.

## Operation
- Transfer occurs on a rising edge when s_valid && s_ready.
- Header word fields:
  - frame index = s_data[FrameBitsPerRow-1 -: 8]
  - row count N = s_data[7:0]
  - all other bits are ignored.
- State machine (state register and all outputs reset to 0 / IDLE):
  - IDLE: s_ready=1. On a header transfer:
    - Header is invalid if index >= MaxFramesPerCol, N == 0, or N > NumberOfRows. Then set err, stay IDLE, drive no outputs.
    - Otherwise latch index and N, clear row counter r, go to LOAD.
  - LOAD: s_ready=1. On each transfer:
    - FrameData <= s_data; RowSelect <= 1<<r; r <= r+1.
    - When r == N-1, go to STROBE.
  - STROBE: s_ready=0. Set FrameStrobe <= 1<<index and go to IDLE.
- RowSelect and FrameStrobe are cleared on the edge after they are set, so each is a one-cycle pulse.
- FrameData holds its last value between writes.
- Rows N..NumberOfRows-1 are never selected.
- err_clr has priority over a same-cycle set of err.
- s_valid low in LOAD stalls with no timeout; no outputs change while stalled.
- Reset mid-frame: all state is discarded, no strobe is issued, and the partial frame is dropped.

## Timing
- Data word accepted at edge t: FrameData/RowSelect are valid in cycle t+1.
- Last row accepted at edge t:
  - STROBE during cycle t+1; s_ready=0 in cycle t+1.
  - FrameStrobe high in cycle t+2, together with s_ready=1 (IDLE).
- A new header may be accepted in cycle t+2; that acceptance is concurrent with the strobe.
- Minimum frame cost: N+2 cycles (header, N rows, one STROBE bubble).
- All outputs are registered; there is no combinational path from s_valid to s_ready.

## Configuration
- FRAME_CTRL_DONE_COUNT_EN
  - Defined: a 16-bit frames_done counter increments on every cycle FrameStrobe != 0, wraps at 0xFFFF->0, and resets to 0.
  - Undefined: the frames_done port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package frame_cfg_pkg contains:
  - state enum {IDLE, LOAD, STROBE}
  - header field constants HDR_IDX_W=8, HDR_CNT_W=8
- Single module. The one-hot decoder is a function in the package; there is no sub-module.

## Test plan
Defaults apply unless stated (20 frames, 32 bits, 16 rows).

- Reset:
  - Stimulus: hold resetn=0, then release.
  - Response: all outputs 0, s_ready=1 from the first cycle after release.
- Nominal frame:
  - Stimulus: header 0x03000002, data 0xDEADBEEF, then 0x12345678, back-to-back.
  - Response: RowSelect=0x0001 with FrameData 0xDEADBEEF, then RowSelect=0x0002 with FrameData 0x12345678. One cycle with s_ready=0, then FrameStrobe=0x00008 for exactly one cycle. With FRAME_CTRL_DONE_COUNT_EN, frames_done=1.
- Bad headers:
  - Stimulus: 0x14000001 (index 20), then 0x00000000 (N=0), then 0x00000011 (N=17).
  - Response: each is consumed, err=1, no RowSelect/FrameStrobe activity. err_clr clears err.
- Stall:
  - Stimulus: header N=3, with s_valid dropped 5 cycles between rows.
  - Response: RowSelect pulses only on accepted words; FrameStrobe appears 2 cycles after the third row.
- Back-to-back frames:
  - Stimulus: a second header presented in the FrameStrobe cycle.
  - Response: the second header is accepted in that cycle; both frames commit.
- Reset mid-frame:
  - Stimulus: assert resetn=0 after row 1 of N=4.
  - Response: no FrameStrobe; after release, the state is IDLE and the next full frame commits normally.
